// File: rtl/branch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq_pkg
// Description : Shared CPU control-unit constants: branch sequencer state
//               encoding, default ALU add opcode and branch counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_seq_pkg;

    // Branch sequencer control steps
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int         c_CNT_W    = 16;
    localparam int         c_ALU_OP_W = 5;
    localparam logic [4:0] c_ADD_OP   = 5'b00011;

    // A sequence is "in progress" only while executing the T3..T6 steps
    function automatic logic is_busy(input state_t s);
        return (s == ST_T3) || (s == ST_T4) || (s == ST_T5) || (s == ST_T6);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cnt.sv
`default_nettype none
// ============================================================================
// Module      : branch_cnt
// Description : Wrapping up-counter with enable, used for branch statistics.
// Ports       : clk     - clock
//               reset   - asynchronous active-low reset (clears count)
//               i_en    - increment by one on the next rising edge
//               o_count - current count, wraps from all-ones to zero
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cnt
    import branch_seq_pkg::*;
#(
    parameter int WIDTH = c_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Natural modulo-2^WIDTH wrap on overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq
// Description : Control sequencer for a conditional branch instruction.
//               Steps T3..T6 evaluate the condition, add the branch offset
//               to the PC and conditionally load the new PC. Moore outputs.
// Ports       : clk, reset (async active-low)
//               start  - pulse: IR holds a branch, begin sequence
//               stall  - hold current step (memory/bus not ready)
//               con    - condition flip-flop output
//               Gra..PCin - datapath control strobes
//               alu_op - ALU operation select
//               busy   - sequence in progress (T3..T6)
//               done   - one-cycle completion pulse
//               taken  - outcome of the last completed branch
//               br_total, br_taken - completed / taken branch counts
// Revision    : 1.0 - initial release
// ============================================================================
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int                  ALU_OP_W = c_ALU_OP_W,
    parameter logic [ALU_OP_W-1:0] ADD_OP   = ALU_OP_W'(c_ADD_OP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                con,
    output logic                Gra,
    output logic                Rout,
    output logic                CONin,
    output logic                PCout,
    output logic                Yin,
    output logic                Cout,
    output logic                Zin,
    output logic                Zlowout,
    output logic                PCin,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                taken,
    output logic [c_CNT_W-1:0]  br_total,
    output logic [c_CNT_W-1:0]  br_taken
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_cond_q;
    logic   r_taken;
    logic   w_capture;
    logic   w_retire;

    // The condition is sampled only on the edge that leaves T4, and the
    // branch retires only on the edge that leaves T6; a stall blocks both.
    assign w_capture = (r_state == ST_T4) && !stall;
    assign w_retire  = (r_state == ST_T6) && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cond_q <= 1'b0;
            r_taken  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cond_q <= con;
            end
            if (w_retire) begin
                r_taken <= r_cond_q;
            end
        end
    end

    // Next state and Moore output decode (state + registered cond_q only)
    always_comb begin
        w_state_nxt = r_state;
        Gra         = 1'b0;
        Rout        = 1'b0;
        CONin       = 1'b0;
        PCout       = 1'b0;
        Yin         = 1'b0;
        Cout        = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        PCin        = 1'b0;
        alu_op      = '0;
        done        = 1'b0;
        busy        = is_busy(r_state);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_T3;
                end
            end
            ST_T3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
                if (!stall) begin
                    w_state_nxt = ST_T4;
                end
            end
            ST_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
                if (!stall) begin
                    w_state_nxt = ST_T5;
                end
            end
            ST_T5: begin
                Cout   = 1'b1;
                Zin    = 1'b1;
                alu_op = ADD_OP;
                if (!stall) begin
                    w_state_nxt = ST_T6;
                end
            end
            ST_T6: begin
                Zlowout = 1'b1;
                PCin    = r_cond_q;
                if (!stall) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    branch_cnt #(
        .WIDTH (c_CNT_W)
    ) u_cnt_total (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_retire),
        .o_count (br_total)
    );

    branch_cnt #(
        .WIDTH (c_CNT_W)
    ) u_cnt_taken (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_retire & r_cond_q),
        .o_count (br_taken)
    );

    assign taken = r_taken;

endmodule
`default_nettype wire
